uart_tx_tick: RTL

// - UART transmitter, 8N1 by default. Serializes one byte per transfer onto tx.
// - Sits directly downstream of the bit-period timer (217-clock period at 50 MHz = 4.34 us, ~230400 baud).
// - Consumes that timer's one-cycle rollover pulse as bit_tick.
// - Has no internal baud counter: every bit boundary is a bit_tick.

---
 rtl/uart_tx_tick.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: UART serializer with no baud counter of its own; every bit
// boundary is an external one-cycle bit_tick. Frame: start, data LSB first, [parity], stop(s).
module uart_tx_tick #(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 bit_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_done
);

   localparam int            CW        = $clog2(DATA_BITS) + 1;
   localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_reg;
   logic [DATA_BITS-1:0] shreg_reg;
   logic [CW-1:0]        bit_cnt_reg;
   logic                 stop_cnt_reg;
   logic                 parity_reg;
   logic                 tx_reg;
   logic                 tx_ready_reg;
   logic                 tx_done_reg;
   logic                 parity_next;

   // Even parity is the XOR of the payload; odd parity is its inverse.
   always_comb begin
      parity_next = ^tx_data;
      if (PARITY == 2) begin
         parity_next = ~parity_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         shreg_reg    <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= 1'b0;
         parity_reg   <= 1'b0;
         tx_reg       <= 1'b1;
         tx_ready_reg <= 1'b1;
         tx_done_reg  <= 1'b0;
      end else begin
         tx_done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               tx_reg       <= 1'b1;
               tx_ready_reg <= 1'b1;
               // A tick coincident with the accept is deliberately ignored;
               // ARM then waits for the next one so the start bit is a full period.
               if (tx_valid && tx_ready_reg) begin
                  shreg_reg    <= tx_data;
                  parity_reg   <= parity_next;
                  tx_ready_reg <= 1'b0;
                  state_reg    <= S_ARM;
               end
            end
            S_ARM: begin
               tx_reg <= 1'b1;
               if (bit_tick) begin
                  tx_reg    <= 1'b0;
                  state_reg <= S_START;
               end
            end
            S_START: begin
               if (bit_tick) begin
                  tx_reg      <= shreg_reg[0];
                  shreg_reg   <= shreg_reg >> 1;
                  bit_cnt_reg <= '0;
                  state_reg   <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_tick) begin
                  if (bit_cnt_reg == LAST_BIT) begin
                     if (PARITY != 0) begin
                        tx_reg    <= parity_reg;
                        state_reg <= S_PARITY;
                     end else begin
                        tx_reg       <= 1'b1;
                        stop_cnt_reg <= 1'b0;
                        state_reg    <= S_STOP;
                     end
                  end else begin
                     tx_reg      <= shreg_reg[0];
                     shreg_reg   <= shreg_reg >> 1;
                     bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                  end
               end
            end
            S_PARITY: begin
               if (bit_tick) begin
                  tx_reg       <= 1'b1;
                  stop_cnt_reg <= 1'b0;
                  state_reg    <= S_STOP;
               end
            end
            S_STOP: begin
               tx_reg <= 1'b1;
               if (bit_tick) begin
                  if (stop_cnt_reg == LAST_STOP) begin
                     tx_done_reg  <= 1'b1;
                     tx_ready_reg <= 1'b1;
                     state_reg    <= S_IDLE;
                  end else begin
                     stop_cnt_reg <= stop_cnt_reg + 1'b1;
                  end
               end
            end
            default: begin
               tx_reg       <= 1'b1;
               tx_ready_reg <= 1'b1;
               state_reg    <= S_IDLE;
            end
         endcase
      end
   end

   assign tx       = tx_reg;
   assign tx_ready = tx_ready_reg;
   assign tx_done  = tx_done_reg;

endmodule
